xvga_timing: RTL
================

Name: xvga_timing

Overview:
- Raster timing generator for the 1024x768@60 (65 MHz) display path.
- Produces the hcount/vcount beam coordinates consumed by the circle/sprite renderers, plus hsync, vsync and blank for the DAC/connector.
- Sync and blank can be delayed to line up with the pipeline latency of downstream pixel generators.
- Sits directly upstream of every per-pixel renderer; one instance per display.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync pulse width (clocks)
- H_BP, 160, horizontal back porch (clocks); H_TOTAL = sum = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 806
- SYNC_DELAY, 0, extra clocks of delay applied to hsync/vsync/blank/frame_start (0..15)

Ports:
- vclock  in  1  pixel clock, 65 MHz, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- hcount  out  11  horizontal position, 0..H_TOTAL-1
- vcount  out  10  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank  out  1  high outside the active area
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- frame_count  out  16  frames completed; present only with XVGA_FRAME_CNT_EN

Behaviour:
- Reset is asynchronous and active-low. While reset_n=0:
  - hcount=0, vcount=0
  - hsync=1, vsync=1, blank=0, frame_start=0
  - every SYNC_DELAY stage holds these same values
  - frame_count=0
- Release is synchronous to vclock. On the first rising edge after release, hcount becomes 1.
- hcount increments by 1 every clock.
  - When hcount=H_TOTAL-1, hcount wraps to 0 on the next clock.
  - On that same edge, vcount increments.
- vcount wraps from V_TOTAL-1 to 0 at the same edge where hcount wraps from H_TOTAL-1. Both counters reach 0 on one edge; there is no intermediate state.
- All outputs are registered: no combinational path from the counters to the pins. With SYNC_DELAY=0, hsync/vsync/blank/frame_start are decoded from the next-state count, so they describe the hcount/vcount pair shown in the same cycle.
- Decode rules:
  - hsync=0 iff H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1 (1048..1183 default)
  - vsync=0 iff V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1 (771..776 default). vsync changes only at hcount=0 boundaries.
  - blank=1 iff hcount>=H_ACTIVE or vcount>=V_ACTIVE
  - frame_start=1 iff hcount=0 and vcount=0, except in the reset cycle and the cycle immediately after it. The first pulse after reset is the first wrap to (0,0).
- SYNC_DELAY=N>0: hsync/vsync/blank/frame_start pass through an N-stage shift register, so they lag hcount/vcount by exactly N clocks. hcount/vcount are never delayed.
- Count widths are fixed at 11/10 bits. Parameter sets with H_TOTAL>2048 or V_TOTAL>1024 are illegal and are flagged by an elaboration-time check.
- Reset mid-frame: counters and all delay stages clear immediately, asynchronously. No partial sync pulse survives past reset assertion.

Optional Feature:
- Macro: XVGA_FRAME_CNT_EN.
- Defined:
  - frame_count exists.
  - It increments by 1, wrapping at 65535, on the same edge where the undelayed counters go to (0,0).
  - It resets to 0.
- Undefined: no frame_count port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset behaviour: hold reset_n=0 for 10 clocks, then release. Required: hcount=0, vcount=0, hsync=1, vsync=1, blank=0 during reset; hcount=1 after the first edge after release.
- Line wrap: run to hcount=1343, vcount=5. Required next cycle: hcount=0, vcount=6. Required over the line: hsync low for exactly 136 clocks starting at hcount=1048; blank rises at hcount=1024.
- Frame wrap: run to hcount=1343, vcount=805. Required next cycle: (0,0) with frame_start=1 for one cycle only. Required over the frame: vsync low during vcount 771..776 (6 lines = 8064 clocks); blank=1 for all of vcount>=768.
- SYNC_DELAY=5: each hsync/blank/frame_start edge lags the SYNC_DELAY=0 instance by exactly 5 clocks; hcount/vcount are identical between the two instances.
- Mid-frame reset: assert reset_n=0 asynchronously at hcount=1100 (hsync low). Required: hsync=1 and hcount=0 without waiting for a clock edge; after release the count restarts from 0.
- XVGA_FRAME_CNT_EN: run 3 full frames (3*1344*806 clocks). Required: frame_count=3. Preload/force to 65535, then one more frame. Required: frame_count=0.

Source files
------------

// File: rtl/xvga_timing.sv
// xvga_timing: raster timing generator for the 1024x768@60 (65 MHz) display path.
// Drives hcount/vcount beam coordinates plus registered hsync/vsync/blank/frame_start.
// Sync outputs can be delayed by SYNC_DELAY clocks to match downstream pixel latency.
// Optional feature: define XVGA_FRAME_CNT_EN to add the 16-bit frame_count output.
module xvga_timing #(
    parameter int H_ACTIVE   = 1024,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BP       = 160,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 29,
    parameter int SYNC_DELAY = 0
) (
    input  logic        vclock,
    input  logic        reset_n,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_start
`ifdef XVGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Fixed-width decode thresholds so every comparison is 11/10 bits wide.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_L  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Count widths are fixed; reject timings that cannot be represented.
    if (H_TOTAL > 2048) begin : g_h_range_chk
        $error("xvga_timing: H_TOTAL exceeds the 11-bit hcount range");
    end
    if (V_TOTAL > 1024) begin : g_v_range_chk
        $error("xvga_timing: V_TOTAL exceeds the 10-bit vcount range");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 15) begin : g_dly_range_chk
        $error("xvga_timing: SYNC_DELAY must be within 0..15");
    end

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic fs;
    } sync_t;

    // Idle value of every delay stage: syncs inactive, not blanked, no pulse.
    localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0};

    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        h_wrap;
    sync_t       sync_d;
    // Stage 0 lines up with the counters; stage N lags them by N clocks.
    sync_t       sync_q [0:SYNC_DELAY];

    // Next beam position: hcount steps every clock, vcount steps on line wrap.
    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? 11'd0 : h_q + 11'd1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
    end

    // Decode from the next-state position so the registered syncs match the counters.
    always_comb begin
        sync_d.hs    = !((h_d >= HS_START) && (h_d <= HS_END));
        sync_d.vs    = !((v_d >= VS_START) && (v_d <= VS_END));
        sync_d.blank = (h_d >= H_ACT_L) || (v_d >= V_ACT_L);
        sync_d.fs    = (h_d == 11'd0) && (v_d == 10'd0);
    end

    // Beam counters and the sync delay line; everything clears asynchronously.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
            for (int i = 0; i <= SYNC_DELAY; i++) begin
                sync_q[i] <= SYNC_RST;
            end
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            sync_q[0] <= sync_d;
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign hsync       = sync_q[SYNC_DELAY].hs;
    assign vsync       = sync_q[SYNC_DELAY].vs;
    assign blank       = sync_q[SYNC_DELAY].blank;
    assign frame_start = sync_q[SYNC_DELAY].fs;

`ifdef XVGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Count completed frames on the edge that returns the undelayed beam to (0,0).
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (h_wrap && (v_q == V_LAST)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

endmodule
